wb_ep_tx_fifo: RTL and testbench
================================

// Module: wb_ep_tx_fifo
// PURPOSE
//  Wishbone classic slave on the bus driven by the TT pin-to-wishbone master. It buffers
//  32-bit words written by the host CPU into a FIFO, then serialises a committed packet of
//  LEN bytes onto an 8-bit valid/ready stream. The stream feeds the USB device TX endpoint
//  engine.
// PARAMETERS
//  DEPTH_LOG2  4        FIFO depth = 2**DEPTH_LOG2 words of 32 bits
//  BASE_ADR    14'h0100 word base address; block decodes wb_ADR[13:2]==BASE_ADR[13:2]
// PORTS
//  clk          in   1   clock; all logic on posedge
//  reset        in   1   synchronous, active-high reset
//  wb_CYC       in   1   bus cycle
//  wb_STB       in   1   strobe
//  wb_WE        in   1   1=write
//  wb_ADR       in  14   word address; [1:0] selects register
//  wb_SEL       in   4   byte lanes; writes take effect only when 4'hF
//  wb_DAT_MOSI  in  32   write data
//  wb_DAT_MISO  out 32   read data, valid while wb_ACK=1, else 0
//  wb_ACK       out  1   single-cycle acknowledge
//  out_valid    out  1   stream byte valid
//  out_data     out  8   stream byte
//  out_last     out  1   final byte of packet (qualifies out_valid)
//  out_ready    in   1   consumer accepts byte when out_valid&out_ready
// BEHAVIOUR
//  Reset: wb_ACK=0, wb_DAT_MISO=0, out_valid=0, out_data=0, out_last=0; FIFO empty, LEN=0,
//   overflow=0, done=0, serializer IDLE.
//  Bus: sel = wb_CYC & wb_STB & address hit. wb_ACK <= sel & !wb_ACK, giving one wait state
//   and ACK exactly 1 cycle. A held STB after ACK yields no second ACK in the next cycle.
//  Register side effects occur only on the edge that raises wb_ACK (once per transaction).
//  Unhit address: no ACK. Write with wb_SEL!=4'hF: ACKed, no effect.
//  Regs (wb_ADR[1:0]):
//   0 DATA   W: push word into FIFO; R: 0
//   1 STATUS R: [7:0]=level (word count), [16]=empty, [17]=full, [18]=overflow(sticky),
//            [19]=busy, [20]=done(sticky); writes ignored
//   2 CTRL   W: [0]=flush, [1]=clear overflow+done, [2]=send; R: 0 (self-clearing bits)
//   3 LEN    RW [10:0] packet byte count; other bits read 0
//  FIFO: push when full -> word dropped, overflow<=1, still ACKed. Simultaneous push and pop
//   -> both occur, level unchanged. Pointers wrap mod 2**DEPTH_LOG2; level width DEPTH_LOG2+1.
//  Serializer FSM IDLE->SEND->IDLE:
//   IDLE: send=1 & LEN!=0 -> SEND, remaining<=LEN, byte index<=0.
//         send=1 & LEN==0 -> done<=1, stay IDLE.
//         send while SEND is ignored.
//   SEND: out_valid=1 when FIFO non-empty. out_data = head word byte[idx], LSB byte first.
//         out_last=(remaining==1). On handshake: remaining--, idx++.
//         Head is popped after idx==3 or after the last byte; surplus bytes of a partial
//         final word are discarded.
//         FIFO empty mid-packet -> out_valid=0 (stall, no error).
//         Last handshake -> IDLE, done<=1.
//   out_data/out_last change only after a handshake or while out_valid=0 (AXI-style hold).
//   busy = (state==SEND).
//  Flush: empties FIFO, forces IDLE, out_valid<=0 next cycle, done unchanged.
//   Flush and send written in the same word: flush wins, send ignored.
//  Reset mid-packet: abort immediately, all state to reset values.
// CONFIGURATION
//  WB_EP_TX_FIFO_IRQ_EN defined: adds output port irq (1 bit, reset 0) plus CTRL[3]=irq_en
//   (RW, reset 0). irq registered = done & irq_en; cleared via CTRL[1].
//  Undefined: no irq port, CTRL[3] ignored and reads 0; the done bit is still present.
// TESTING
//  1 Write DATA 0x44332211, LEN=3, CTRL=4, out_ready=1 -> bytes 11,22,33, last on 33;
//    FIFO empty; STATUS[20]=1, [19]=0.
//  2 Push 2**DEPTH_LOG2+1 words -> STATUS level=16, full=1, overflow=1; all 17 writes ACKed
//    exactly 1 cycle after STB.
//  3 LEN=6, send with FIFO empty -> out_valid=0. Push 0x04030201, then 0x08070605 ->
//    bytes 01..04,05,06 with last on 06; 07/08 discarded; level=0.
//  4 out_ready toggled 1/0 during 8-byte packet -> out_data held stable while stalled;
//    no byte lost or duplicated.
//  5 Flush during SEND after 2 bytes -> out_valid=0 next cycle; STATUS=0x00010000 (empty),
//    busy=0.
//  6 LEN=0 send -> no out_valid, done=1. With IRQ_EN and CTRL=8 -> irq=1;
//    CTRL=2 -> irq=0, done=0.

Source files
------------

// File: rtl/wb_ep_tx_fifo.sv
// wb_ep_tx_fifo
//   Wishbone classic slave that buffers 32-bit words from the host CPU in a
//   FIFO and serialises a committed packet of LEN bytes, least significant
//   byte of each word first, onto an 8-bit valid/ready stream for the USB TX
//   endpoint engine.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   wb_CYC/STB/WE     Wishbone cycle, strobe, write enable
//   wb_ADR[13:0]      word address; [13:2] decoded against BASE_ADR, [1:0] register
//   wb_SEL[3:0]       byte lanes; only full-word writes take effect
//   wb_DAT_MOSI[31:0] write data
//   wb_DAT_MISO[31:0] read data, non-zero only while wb_ACK is high
//   wb_ACK            single-cycle acknowledge after one wait state
//   out_valid/out_data[7:0]/out_last/out_ready   byte stream
//   irq               (only with WB_EP_TX_FIFO_IRQ_EN) done & irq_en, registered
//
// Registers (wb_ADR[1:0])
//   0 DATA   W push word, R 0
//   1 STATUS R [7:0] level, [16] empty, [17] full, [18] overflow, [19] busy, [20] done
//   2 CTRL   W [0] flush, [1] clear overflow+done, [2] send, [3] irq_en (IRQ build only)
//   3 LEN    RW [10:0] packet byte count
//
// Build option: define WB_EP_TX_FIFO_IRQ_EN to add the irq output and CTRL[3].

module wb_ep_tx_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [13:0] BASE_ADR   = 14'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_CYC,
  input  logic        wb_STB,
  input  logic        wb_WE,
  input  logic [13:0] wb_ADR,
  input  logic [3:0]  wb_SEL,
  input  logic [31:0] wb_DAT_MOSI,
  output logic [31:0] wb_DAT_MISO,
  output logic        wb_ACK,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready
`ifdef WB_EP_TX_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   level;
  logic                  empty, full;
  logic                  overflow, done;
  logic [10:0]           len;
  state_t                state;
  logic [10:0]           remaining;
  logic [1:0]            idx, idx_inc;
  logic [31:0]           head, head_nxt;
  logic [31:0]           status, rd_val;

  logic hit, sel, fire, wr_ok;
  logic wr_data, wr_ctrl, wr_len;
  logic flush, clr, send;
  logic push, pop, handshake, is_last;

`ifdef WB_EP_TX_FIFO_IRQ_EN
  logic irq_en;
`endif

  // Bus decode: side effects only on the edge that raises ACK.
  assign hit     = (wb_ADR[13:2] == BASE_ADR[13:2]);
  assign sel     = wb_CYC & wb_STB & hit;
  assign fire    = sel & ~wb_ACK;
  assign wr_ok   = fire & wb_WE & (wb_SEL == 4'hF);
  assign wr_data = wr_ok & (wb_ADR[1:0] == 2'd0);
  assign wr_ctrl = wr_ok & (wb_ADR[1:0] == 2'd2);
  assign wr_len  = wr_ok & (wb_ADR[1:0] == 2'd3);

  // Flush dominates send when both are written in the same word.
  assign flush = wr_ctrl & wb_DAT_MOSI[0];
  assign clr   = wr_ctrl & wb_DAT_MOSI[1];
  assign send  = wr_ctrl & wb_DAT_MOSI[2] & ~wb_DAT_MOSI[0];

  assign empty      = (level == '0);
  assign full       = (level == LVL_FULL);
  assign rd_ptr_nxt = rd_ptr + DEPTH_LOG2'(1);
  assign head       = mem[rd_ptr];
  assign head_nxt   = mem[rd_ptr_nxt];
  assign idx_inc    = idx + 2'd1;

  assign handshake = out_valid & out_ready;
  assign is_last   = (remaining == 11'd1);
  assign push      = wr_data & ~full;
  // A head word leaves the FIFO after its fourth byte or after the packet's
  // final byte, so the tail of a partial last word is discarded.
  assign pop       = handshake & ((idx == 2'd3) | is_last) & ~flush;

  always_comb begin
    status         = '0;
    status[7:0]    = 8'(level);
    status[16]     = empty;
    status[17]     = full;
    status[18]     = overflow;
    status[19]     = (state == SEND);
    status[20]     = done;
  end

  always_comb begin
    rd_val = '0;
    case (wb_ADR[1:0])
      2'd1:    rd_val = status;
`ifdef WB_EP_TX_FIFO_IRQ_EN
      2'd2:    rd_val = {28'd0, irq_en, 3'd0};
`endif
      2'd3:    rd_val = {21'd0, len};
      default: rd_val = '0;
    endcase
  end

  // Bus handshake, read data and the plain configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ACK      <= 1'b0;
      wb_DAT_MISO <= '0;
      len         <= '0;
`ifdef WB_EP_TX_FIFO_IRQ_EN
      irq_en      <= 1'b0;
`endif
    end else begin
      wb_ACK      <= fire;
      wb_DAT_MISO <= (fire & ~wb_WE) ? rd_val : '0;
      if (wr_len)
        len <= wb_DAT_MOSI[10:0];
`ifdef WB_EP_TX_FIFO_IRQ_EN
      if (wr_ctrl)
        irq_en <= wb_DAT_MOSI[3];
`endif
    end
  end

  // Storage array has no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wb_DAT_MOSI;
  end

  // FIFO pointers, level and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (pop)
          rd_ptr <= rd_ptr_nxt;
        case ({push, pop})
          2'b10:   level <= level + LVL_ONE;
          2'b01:   level <= level - LVL_ONE;
          default: level <= level;
        endcase
      end
      if (clr)
        overflow <= 1'b0;
      if (wr_data & full)
        overflow <= 1'b1;
    end
  end

  // Serializer. The stream outputs are registered and look one byte ahead:
  // after a handshake they load the following byte directly, so a full FIFO
  // streams at one byte per cycle. When the next word is not yet stored the
  // valid drops and the idle branch reloads once data arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (clr)
        done <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        remaining <= '0;
        idx       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (send) begin
              if (len != 11'd0) begin
                state     <= SEND;
                remaining <= len;
                idx       <= '0;
                out_valid <= 1'b0;
              end else begin
                done <= 1'b1;
              end
            end
          end
          SEND: begin
            if (handshake) begin
              remaining <= remaining - 11'd1;
              idx       <= idx_inc;
              out_last  <= (remaining == 11'd2);
              if (is_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                done      <= 1'b1;
              end else if (idx == 2'd3) begin
                out_valid <= (level > LVL_ONE);
                if (level > LVL_ONE)
                  out_data <= head_nxt[7:0];
              end else begin
                out_valid <= 1'b1;
                out_data  <= head[{idx_inc, 3'b000} +: 8];
              end
            end else if (!out_valid && !empty) begin
              out_valid <= 1'b1;
              out_data  <= head[{idx, 3'b000} +: 8];
              out_last  <= is_last;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef WB_EP_TX_FIFO_IRQ_EN
  // Interrupt follows done one cycle later, gated by the enable.
  always_ff @(posedge clk) begin
    if (reset)
      irq <= 1'b0;
    else
      irq <= done & irq_en;
  end
`endif

endmodule

// File: tb/tb_wb_ep_tx_fifo.sv
// tb_wb_ep_tx_fifo
//   Directed self-checking bench for wb_ep_tx_fifo. Each task drives one
//   scenario and compares observed values against hand-computed constants.
//   Define WB_EP_TX_FIFO_IRQ_EN to also exercise the irq output.

module tb_wb_ep_tx_fifo;

  localparam logic [13:0] BASE = 14'h0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_CYC, wb_STB, wb_WE;
  logic [13:0] wb_ADR;
  logic [3:0]  wb_SEL;
  logic [31:0] wb_DAT_MOSI;
  logic [31:0] wb_DAT_MISO;
  logic        wb_ACK;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
`ifdef WB_EP_TX_FIFO_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_data [16];
  bit         got_last [16];

  wb_ep_tx_fifo #(.DEPTH_LOG2(4), .BASE_ADR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_CYC      (wb_CYC),
    .wb_STB      (wb_STB),
    .wb_WE       (wb_WE),
    .wb_ADR      (wb_ADR),
    .wb_SEL      (wb_SEL),
    .wb_DAT_MOSI (wb_DAT_MOSI),
    .wb_DAT_MISO (wb_DAT_MISO),
    .wb_ACK      (wb_ACK),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready)
`ifdef WB_EP_TX_FIFO_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  // Holds reset for a few cycles and releases it just after an edge.
  task automatic do_reset();
    wb_CYC = 0; wb_STB = 0; wb_WE = 0; wb_ADR = '0; wb_SEL = '0;
    wb_DAT_MOSI = '0; out_ready = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
  endtask

  // One Wishbone transaction; ack_cyc is the number of edges until ACK, -1 on timeout.
  task automatic wb_xfer(input logic [1:0] rg, input bit we, input logic [3:0] sl,
                         input logic [31:0] dat, output logic [31:0] rdata,
                         output int ack_cyc);
    bit seen;
    seen = 0;
    ack_cyc = -1;
    rdata = '0;
    @(posedge clk);
    #1;
    wb_CYC = 1; wb_STB = 1; wb_WE = we; wb_SEL = sl;
    wb_ADR = {BASE[13:2], rg}; wb_DAT_MOSI = dat;
    for (int i = 1; i <= 8; i++) begin
      if (!seen) begin
        @(posedge clk);
        #1;
        if (wb_ACK) begin
          seen = 1;
          ack_cyc = i;
          rdata = wb_DAT_MISO;
        end
      end
    end
    wb_CYC = 0; wb_STB = 0; wb_WE = 0;
  endtask

  task automatic wr(input logic [1:0] rg, input logic [31:0] dat);
    logic [31:0] r;
    int a;
    wb_xfer(rg, 1'b1, 4'hF, dat, r, a);
  endtask

  task automatic rd(input logic [1:0] rg, output logic [31:0] dat);
    int a;
    wb_xfer(rg, 1'b0, 4'hF, 32'd0, dat, a);
  endtask

  // Receives n stream bytes; toggle alternates out_ready 1/0 and verifies
  // that a stalled byte is held unchanged.
  task automatic collect(input int n, input bit toggle, output int got);
    bit pv, pr;
    logic [7:0] pd;
    int cyc;
    got = 0; pv = 0; pr = 0; pd = '0; cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      out_ready = toggle ? (cyc[0] == 1'b0) : 1'b1;
      if (pv && !pr) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd) begin
          failures++;
          $display("[TB] FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                   out_valid, out_data, pd);
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      if (out_valid && out_ready) begin
        got_data[got] = out_data;
        got_last[got] = out_last;
        got++;
      end
      cyc++;
    end
    @(posedge clk);
    #1 out_ready = 0;
    checks++;
    if (got != n) begin
      failures++;
      $display("[TB] FAIL byte_count: got %0d bytes, required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int a;
    do_reset();
    checks++;
    if (wb_ACK !== 1'b0 || wb_DAT_MISO !== 32'd0 || out_valid !== 1'b0 ||
        out_data !== 8'd0 || out_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: ack=%b miso=%h valid=%b data=%h last=%b, required all 0",
               wb_ACK, wb_DAT_MISO, out_valid, out_data, out_last);
    end
    rd(2'd1, r);
    checks++;
    if (r !== 32'h0001_0000) begin
      failures++;
      $display("[TB] FAIL reset_status: got %h, required 00010000", r);
    end
    // Partial-lane write is acknowledged but leaves LEN untouched.
    wb_xfer(2'd3, 1'b1, 4'h3, 32'h0000_0005, r, a);
    checks++;
    if (a !== 1) begin
      failures++;
      $display("[TB] FAIL partial_sel_ack: ack after %0d cycles, required 1", a);
    end
    rd(2'd3, r);
    checks++;
    if (r !== 32'd0) begin
      failures++;
      $display("[TB] FAIL partial_sel_len: got %h, required 0", r);
    end
    // Unhit address: never acknowledged.
    @(posedge clk);
    #1;
    wb_CYC = 1; wb_STB = 1; wb_WE = 0; wb_ADR = 14'h0000; wb_SEL = 4'hF;
    a = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (wb_ACK) a++;
    end
    wb_CYC = 0; wb_STB = 0;
    checks++;
    if (a != 0) begin
      failures++;
      $display("[TB] FAIL unhit_ack: saw %0d acks, required 0", a);
    end
    // Held strobe: ACK for exactly one cycle, then low.
    @(posedge clk);
    #1;
    wb_CYC = 1; wb_STB = 1; wb_WE = 0; wb_ADR = {BASE[13:2], 2'd1};
    @(posedge clk);
    #1 a = {31'd0, wb_ACK};
    @(posedge clk);
    #1;
    checks++;
    if (a != 1 || wb_ACK !== 1'b0) begin
      failures++;
      $display("[TB] FAIL held_stb: ack sequence %0d,%b, required 1,0", a, wb_ACK);
    end
    wb_CYC = 0; wb_STB = 0;
  endtask

  task automatic test_basic_packet();
    logic [31:0] r;
    logic [7:0]  exp_d [3];
    int got;
    exp_d = '{8'h11, 8'h22, 8'h33};
    do_reset();
    wr(2'd0, 32'h4433_2211);
    wr(2'd3, 32'd3);
    wr(2'd2, 32'd4);
    collect(3, 1'b0, got);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i < got && (got_data[i] !== exp_d[i] || got_last[i] !== (i == 2))) begin
        failures++;
        $display("[TB] FAIL basic_byte%0d: data=%h last=%b, required data=%h last=%b",
                 i, got_data[i], got_last[i], exp_d[i], (i == 2));
      end
    end
    rd(2'd1, r);
    checks++;
    if (r !== 32'h0011_0000) begin
      failures++;
      $display("[TB] FAIL basic_status: got %h, required 00110000", r);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int a;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wb_xfer(2'd0, 1'b1, 4'hF, 32'h1000 + i, r, a);
      checks++;
      if (a != 1) begin
        failures++;
        $display("[TB] FAIL push_ack%0d: ack after %0d cycles, required 1", i, a);
      end
    end
    rd(2'd1, r);
    checks++;
    if (r !== 32'h0006_0010) begin
      failures++;
      $display("[TB] FAIL overflow_status: got %h, required 00060010", r);
    end
  endtask

  task automatic test_partial_word();
    logic [31:0] r;
    logic [7:0]  exp_d [6];
    int got, v;
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_reset();
    wr(2'd3, 32'd6);
    wr(2'd2, 32'd4);
    v = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) v++;
    end
    checks++;
    if (v != 0) begin
      failures++;
      $display("[TB] FAIL empty_stall: valid seen %0d cycles, required 0", v);
    end
    wr(2'd0, 32'h0403_0201);
    wr(2'd0, 32'h0807_0605);
    collect(6, 1'b0, got);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i < got && (got_data[i] !== exp_d[i] || got_last[i] !== (i == 5))) begin
        failures++;
        $display("[TB] FAIL partial_byte%0d: data=%h last=%b, required data=%h last=%b",
                 i, got_data[i], got_last[i], exp_d[i], (i == 5));
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL partial_after: valid=%b, required 0", out_valid);
    end
    rd(2'd1, r);
    checks++;
    if (r !== 32'h0011_0000) begin
      failures++;
      $display("[TB] FAIL partial_status: got %h, required 00110000", r);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [8];
    int got;
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    wr(2'd0, 32'h4433_2211);
    wr(2'd0, 32'h8877_6655);
    wr(2'd3, 32'd8);
    wr(2'd2, 32'd4);
    collect(8, 1'b1, got);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i < got && (got_data[i] !== exp_d[i] || got_last[i] !== (i == 7))) begin
        failures++;
        $display("[TB] FAIL bp_byte%0d: data=%h last=%b, required data=%h last=%b",
                 i, got_data[i], got_last[i], exp_d[i], (i == 7));
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    int got;
    do_reset();
    wr(2'd0, 32'h4433_2211);
    wr(2'd0, 32'h8877_6655);
    wr(2'd3, 32'd8);
    wr(2'd2, 32'd4);
    collect(2, 1'b0, got);
    checks++;
    if (got == 2 && (got_data[0] !== 8'h11 || got_data[1] !== 8'h22)) begin
      failures++;
      $display("[TB] FAIL flush_prefix: %h %h, required 11 22", got_data[0], got_data[1]);
    end
    wr(2'd2, 32'd1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_valid: valid=%b, required 0", out_valid);
    end
    rd(2'd1, r);
    checks++;
    if (r !== 32'h0001_0000) begin
      failures++;
      $display("[TB] FAIL flush_status: got %h, required 00010000", r);
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] r;
    int v;
    do_reset();
    wr(2'd3, 32'd0);
    wr(2'd2, 32'd4);
    v = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) v++;
    end
    checks++;
    if (v != 0) begin
      failures++;
      $display("[TB] FAIL zero_len_valid: valid seen %0d cycles, required 0", v);
    end
    rd(2'd1, r);
    checks++;
    if (r !== 32'h0011_0000) begin
      failures++;
      $display("[TB] FAIL zero_len_status: got %h, required 00110000", r);
    end
    wr(2'd2, 32'd8);
    rd(2'd2, r);
`ifdef WB_EP_TX_FIFO_IRQ_EN
    checks++;
    if (r !== 32'd8) begin
      failures++;
      $display("[TB] FAIL ctrl_read: got %h, required 00000008", r);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL irq_set: irq=%b, required 1", irq);
    end
    wr(2'd2, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_clear: irq=%b, required 0", irq);
    end
`else
    checks++;
    if (r !== 32'd0) begin
      failures++;
      $display("[TB] FAIL ctrl_read: got %h, required 00000000", r);
    end
    wr(2'd2, 32'd2);
`endif
    rd(2'd1, r);
    checks++;
    if (r !== 32'h0001_0000) begin
      failures++;
      $display("[TB] FAIL done_clear: got %h, required 00010000", r);
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_overflow();
    test_partial_word();
    test_backpressure();
    test_flush();
    test_zero_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
